vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parameterised raster timing generator that is the upstream stage of the colour-bar/checkerboard pixel stage. It owns the horizontal/vertical counters and produces registered active-low syncs, a data-enable, active-area pixel coordinates and line/frame strobes. The pixel stage consumes these outputs directly, so colour logic needs no counters of its own. Defaults give 1920x1080 at 2200x1125 total.

## Interface
Parameters:
- H_SYNC, 44, hsync pulse width in clocks
- H_BACK, 148, horizontal back porch in clocks
- H_ACTIVE, 1920, active pixels per line
- H_FRONT, 88, horizontal front porch in clocks
- V_SYNC, 5, vsync pulse width in lines
- V_BACK, 36, vertical back porch in lines
- V_ACTIVE, 1080, active lines per frame
- V_FRONT, 4, vertical front porch in lines

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  clock enable; counters and outputs advance only when 1
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- de  out  1  high inside the active area
- x  out  12  active-area column, 0..H_ACTIVE-1
- y  out  12  active-area row, 0..V_ACTIVE-1
- line_start  out  1  one-enabled-cycle strobe at hcnt==0
- frame_start  out  1  one-enabled-cycle strobe at hcnt==0 && vcnt==0
- frame_cnt  out  8  completed-frame counter, wraps 255->0

## Operation
- Internal counters: hcnt 12 bit, vcnt 11 bit. H_TOTAL = sum of the H params (2200). V_TOTAL = sum of the V params (1125). H_START = H_SYNC+H_BACK (192). V_START = V_SYNC+V_BACK (41).
- When pix_en=1:
  - hcnt increments. At H_TOTAL-1 it wraps to 0 and vcnt increments.
  - vcnt wraps from V_TOTAL-1 to 0 at that same hcnt wrap.
- When pix_en=0, counters and all outputs hold. Strobes also hold, so each strobe asserts for exactly one enabled cycle.
- Output decode from the current counter values, registered on the enabled edge:
  - hsync = 0 when hcnt < H_SYNC, else 1.
  - vsync = 0 when vcnt < V_SYNC, else 1.
  - de = 1 when H_START <= hcnt < H_START+H_ACTIVE and V_START <= vcnt < V_START+V_ACTIVE.
  - x = hcnt-H_START and y = vcnt-V_START when de would be 1; otherwise x = 0 and y = 0.
  - line_start = 1 when hcnt == 0. frame_start = 1 when hcnt == 0 and vcnt == 0.
- frame_cnt increments by 1 on the enabled cycle where hcnt==H_TOTAL-1 and vcnt==V_TOTAL-1. The new value is visible together with frame_start.
- rst has priority over pix_en.
  - On rst: hcnt=0, vcnt=0, hsync=1, vsync=1, de=0, x=0, y=0, line_start=0, frame_start=0, frame_cnt=0.
  - Reset mid-line or mid-frame aborts the frame immediately. No partial-frame completion; frame_cnt does not increment.
- The width rule requires H_TOTAL <= 4096 and V_TOTAL <= 2048. Other parameter values are not supported.

## Timing
- Latency: every output is registered and reflects the counter value of the previous enabled edge. Outputs lag the internal counters by exactly one enabled cycle. The downstream colour stage adds its own cycle and must delay its syncs to match.
- First enabled cycle after rst deasserts (counters at 0,0): outputs still show reset values.
- Second enabled cycle: hsync=0, vsync=0, line_start=1, frame_start=1, de=0.
- Per line: hsync is low for H_SYNC enabled cycles. de is high for H_ACTIVE consecutive cycles, with x running 0..H_ACTIVE-1 in step.
- Per frame: vsync is low for V_SYNC full lines. Its edges coincide with the line_start cycle.
- Frame period is H_TOTAL*V_TOTAL enabled cycles (2,475,000 at defaults).

## Test plan
- Reset then pix_en=1, defaults:
  - first de=1 occurs 41*2200+192+1 = 90393 enabled cycles after rst release, with x=0 and y=0.
  - the last de=1 of the frame has x=1919 and y=1079.
- Count per line: hsync low for exactly 44 cycles. de high for 1920 cycles. line_start period 2200. Same counts on every line of two frames.
- Small parameters (H: 2,2,4,2; V: 1,1,3,1):
  - frame_start period is 60 cycles.
  - vsync is low for 10 cycles (one line).
  - x/y scan 0..3 / 0..2 in raster order.
- Random pix_en toggling (50% duty): the sequence of output values over enabled cycles is identical to the pix_en=1 run. Outputs are frozen on every disabled cycle. No strobe lasts more than one enabled cycle.
- frame_cnt wrap with small parameters: after 256 frames, frame_cnt goes 255->0 on the cycle frame_start=1.
- rst asserted for 1 cycle at hcnt=1000, vcnt=500:
  - next cycle all outputs equal their reset values and frame_cnt=0.
  - the frame restarts from (0,0) with frame_start one enabled cycle after the first enabled cycle.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical counters with registered syncs, data-enable,
// active-area coordinates, line/frame strobes and a completed-frame counter.
module vga_timing_gen #(
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BACK   = 148,
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FRONT  = 88,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BACK   = 36,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FRONT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned HTotal  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned VTotal  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned HStartI = H_SYNC + H_BACK;
  localparam int unsigned VStartI = V_SYNC + V_BACK;

  // One bit wider than the counters so an active window ending exactly at the
  // counter range limit still compares correctly.
  localparam logic [12:0] HSyncEnd = 13'(H_SYNC);
  localparam logic [12:0] HStart   = 13'(HStartI);
  localparam logic [12:0] HEnd     = 13'(HStartI + H_ACTIVE);
  localparam logic [12:0] HLast    = 13'(HTotal - 1);
  localparam logic [11:0] VSyncEnd = 12'(V_SYNC);
  localparam logic [11:0] VStart   = 12'(VStartI);
  localparam logic [11:0] VEnd     = 12'(VStartI + V_ACTIVE);
  localparam logic [11:0] VLast    = 12'(VTotal - 1);

  logic [11:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic [12:0] h_ext;
  logic [11:0] v_ext;
  logic        h_last, v_last;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic        line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  frame_cnt_q;

  always_comb begin
    h_ext  = {1'b0, hcnt_q};
    v_ext  = {1'b0, vcnt_q};
    h_last = (h_ext == HLast);
    v_last = (v_ext == VLast);

    hcnt_d = h_last ? 12'd0 : hcnt_q + 12'd1;
    vcnt_d = vcnt_q;
    if (h_last) begin
      vcnt_d = v_last ? 11'd0 : vcnt_q + 11'd1;
    end

    hsync_d       = (h_ext >= HSyncEnd);
    vsync_d       = (v_ext >= VSyncEnd);
    de_d          = (h_ext >= HStart) && (h_ext < HEnd) && (v_ext >= VStart) && (v_ext < VEnd);
    x_d           = de_d ? 12'(h_ext - HStart) : 12'd0;
    y_d           = de_d ? (v_ext - VStart) : 12'd0;
    line_start_d  = (hcnt_q == 12'd0);
    frame_start_d = (hcnt_q == 12'd0) && (vcnt_q == 11'd0);
    frame_done_d  = h_last && v_last;
  end

  // frame_done_q delays the frame count by one enabled edge so the new value
  // appears on the same cycle as frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
    end else if (pix_en) begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_q + {7'd0, frame_done_q};
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small geometries checked every cycle against an arithmetic
// raster model indexed by the number of enabled edges since reset.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
  } out_t;

  logic clk = 1'b0;
  logic rst;
  logic pix_en;
  out_t s_out, m_out;

  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;

  always #5 clk = ~clk;

  // Small geometry: 10 x 6 total, 4 x 3 active.
  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(2), .H_ACTIVE(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1)
  ) u_dut_s (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .hsync      (s_out.hsync),
    .vsync      (s_out.vsync),
    .de         (s_out.de),
    .x          (s_out.x),
    .y          (s_out.y),
    .line_start (s_out.ls),
    .frame_start(s_out.fs),
    .frame_cnt  (s_out.fc)
  );

  // Asymmetric geometry: 17 x 10 total, 7 x 4 active.
  vga_timing_gen #(
    .H_SYNC(3), .H_BACK(5), .H_ACTIVE(7), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(3), .V_ACTIVE(4), .V_FRONT(1)
  ) u_dut_m (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .hsync      (m_out.hsync),
    .vsync      (m_out.vsync),
    .de         (m_out.de),
    .x          (m_out.x),
    .y          (m_out.y),
    .line_start (m_out.ls),
    .frame_start(m_out.fs),
    .frame_cnt  (m_out.fc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      if (err_cnt <= 30) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Outputs after n enabled edges: edge j (0-based) registers the decode of raster position j.
  function automatic out_t model(input int n, input int hs, input int hb, input int ha,
                                 input int hf, input int vs, input int vb, input int va,
                                 input int vf);
    out_t o;
    int ht, vt, ft, j, p, h, v;
    ht = hs + hb + ha + hf;
    vt = vs + vb + va + vf;
    ft = ht * vt;
    if (n == 0) begin
      o = '{hsync: 1'b1, vsync: 1'b1, default: '0};
    end else begin
      j = n - 1;
      p = j % ft;
      h = p % ht;
      v = p / ht;
      o.hsync = (h >= hs);
      o.vsync = (v >= vs);
      o.de    = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < vs + vb + va);
      o.x     = o.de ? 12'(h - hs - hb) : 12'd0;
      o.y     = o.de ? 12'(v - vs - vb) : 12'd0;
      o.ls    = (h == 0);
      o.fs    = (p == 0);
      o.fc    = 8'((j / ft) % 256);
    end
    return o;
  endfunction

  task automatic check_out(input string name, input out_t got, input out_t exp);
    check({name, ".hsync"}, 32'(got.hsync), 32'(exp.hsync));
    check({name, ".vsync"}, 32'(got.vsync), 32'(exp.vsync));
    check({name, ".de"}, 32'(got.de), 32'(exp.de));
    check({name, ".x"}, 32'(got.x), 32'(exp.x));
    check({name, ".y"}, 32'(got.y), 32'(exp.y));
    check({name, ".line_start"}, 32'(got.ls), 32'(exp.ls));
    check({name, ".frame_start"}, 32'(got.fs), 32'(exp.fs));
    check({name, ".frame_cnt"}, 32'(got.fc), 32'(exp.fc));
  endtask

  int          n_en = 0;
  int          first_de_s = -1;
  int          first_de_m = -1;
  int          wraps_seen = 0;
  logic [7:0]  prev_fc_s = 8'd0;

  task automatic step(input logic r, input logic e);
    rst    = r;
    pix_en = e;
    @(posedge clk);
    if (r) n_en = 0;
    else if (e) n_en++;
    @(negedge clk);
    check_out("small", s_out, model(n_en, 2, 2, 4, 2, 1, 1, 3, 1));
    check_out("asym", m_out, model(n_en, 3, 5, 7, 2, 2, 3, 4, 1));
    if (s_out.de && first_de_s < 0) first_de_s = n_en;
    if (m_out.de && first_de_m < 0) first_de_m = n_en;
    if (prev_fc_s == 8'd255 && s_out.fc == 8'd0 && s_out.fs) wraps_seen++;
    prev_fc_s = s_out.fc;
  endtask

  initial begin
    rst    = 1'b1;
    pix_en = 1'b0;
    repeat (3) step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    // Free-running past 256 small frames (60 cycles each).
    repeat (16000) step(1'b0, 1'b1);
    check("first_de_small", 32'(first_de_s), 32'd25);
    check("first_de_asym", 32'(first_de_m), 32'd94);
    check("fc_wrap_small", 32'(wraps_seen), 32'd1);

    repeat (4000) step(1'b0, 1'($urandom_range(0, 1)));

    // Mid-frame abort, then restart under random enable.
    step(1'b1, 1'($urandom_range(0, 1)));
    first_de_s = -1;
    first_de_m = -1;
    repeat (2000) step(1'b0, 1'($urandom_range(0, 1)));
    check("first_de_small_rst", 32'(first_de_s), 32'd25);
    check("first_de_asym_rst", 32'(first_de_m), 32'd94);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
